// File: rtl/ram_pkg.sv
// ram_pkg: shared types, constants and elaboration-time helpers for the
// wait-state RAM controller.
//   state_e    - controller FSM states (IDLE, WAIT, RESP)
//   lane_count - number of byte lanes in a data word
//   cfg_ok     - legality check of the controller parameter set
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MAX_WAIT_STATES = 15;
  localparam int CNT_W           = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Word width must split into whole bytes, the implemented depth must fit
  // the address space and the wait counter is only CNT_W bits wide.
  function automatic bit cfg_ok(input int data_w, input int addr_w,
                                input int depth, input int wait_states);
    return (data_w > 0) && (data_w % 8 == 0) && (depth > 0) &&
           (longint'(depth) <= (longint'(1) << addr_w)) &&
           (wait_states >= 0) && (wait_states <= MAX_WAIT_STATES);
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: word storage with byte-lane writes and a registered read port.
// No reset.
//   clk   in  - clock
//   we    in  - write enable; lanes selected by be are written at the edge
//   waddr in  - write word index
//   wdata in  - write data
//   be    in  - byte enables, bit i covers wdata[8i+7:8i]
//   re    in  - read enable; rdata loads mem[raddr] at the edge
//   raddr in  - read word index
//   rdata out - registered read data, holds between read enables
module ram_array
  import ram_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 2048,
  parameter int    IDX_W     = 11,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_ws_ctrl.sv
// ram_ws_ctrl: single-port RAM controller with byte-lane writes, registered
// reads and a configurable number of read wait states.
//   clk       in  - clock, rising edge
//   rst       in  - synchronous active-high reset
//   req       in  - request valid
//   we        in  - 1 = write, 0 = read (sampled with req)
//   addr      in  - word address (sampled with req)
//   wdata     in  - write data
//   be        in  - byte enables
//   ready     out - a request is accepted this cycle if req is high
//   rdata     out - registered read data
//   rvalid    out - one-cycle read response pulse
//   wack      out - one-cycle write completion pulse
//   err       out - one-cycle pulse with rvalid/wack for addr >= DEPTH
//   state_dbg out - current FSM state
//
// Handshake: a request transfers on a rising edge where req && ready. When
// ready is low the request is ignored (not queued) and the requester keeps
// req asserted. Each accepted request yields exactly one response pulse:
// wack in the cycle after a write accept, rvalid WAIT_STATES+1 cycles after
// a read accept. Writes may be accepted every cycle; reads block further
// requests until their response cycle has passed.
module ram_ws_ctrl
  import ram_pkg::*;
#(
  parameter int    DATA_W      = 16,
  parameter int    ADDR_W      = 12,
  parameter int    DEPTH       = 2048,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "readmem/data.mem"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                wack,
  output logic                err,
  output state_e              state_dbg
);

  if (!cfg_ok(DATA_W, ADDR_W, DEPTH, WAIT_STATES)) begin : g_cfg_bad
    $error("ram_ws_ctrl: illegal DATA_W/ADDR_W/DEPTH/WAIT_STATES combination");
  end

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvalid_q, rvalid_d;
  logic              wack_q, wack_d;
  logic              err_q, err_d;
  // Forces rdata to zero after reset and after an out-of-range read, so the
  // reset-free array register never leaks stale data.
  logic              rzero_q, rzero_d;

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] rd_addr;
  logic              arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  assign ready  = (state_q == IDLE) && !rst;
  assign accept = req && ready;

  // With no wait states the array is read on the accept edge itself, before
  // addr_q holds the address, so the live address is used from IDLE.
  assign rd_addr = (state_q == IDLE) ? addr : addr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && !we) begin
          addr_d = addr;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid_d = enter_resp;
    wack_d   = accept && we;
    err_d    = (accept && we && !in_range(addr)) ||
               (enter_resp && !in_range(rd_addr));
    rzero_d  = enter_resp ? !in_range(rd_addr) : rzero_q;
  end

  assign arr_we = accept && we && in_range(addr);
  assign arr_re = enter_resp && !rst && in_range(rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
      rzero_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
      rzero_q  <= rzero_d;
    end
  end

  ram_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (addr[IDX_W-1:0]),
    .wdata (wdata),
    .be    (be),
    .re    (arr_re),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  assign rdata     = rzero_q ? '0 : arr_rdata;
  assign rvalid    = rvalid_q;
  assign wack      = wack_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_ws_ctrl.sv
// tb_ram_ws_ctrl: two controllers (WAIT_STATES 0 and 2) share one stimulus
// stream. A transaction-level model predicts, per instance, which requests
// are accepted, when each response pulse appears and what rdata shows.
module tb_ram_ws_ctrl;
  import ram_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2048;
  localparam int BE_W   = DATA_W / 8;
  localparam int NDUT   = 2;

  function automatic int ws_of(input int d);
    return 2 * d;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;

  logic              ready_o  [NDUT];
  logic [DATA_W-1:0] rdata_o  [NDUT];
  logic              rvalid_o [NDUT];
  logic              wack_o   [NDUT];
  logic              err_o    [NDUT];
  state_e            dbg_o    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ram_ws_ctrl #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .DEPTH       (DEPTH),
      .WAIT_STATES (2 * g),
      .INIT_FILE   ("")
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .be        (be),
      .ready     (ready_o[g]),
      .rdata     (rdata_o[g]),
      .rvalid    (rvalid_o[g]),
      .wack      (wack_o[g]),
      .err       (err_o[g]),
      .state_dbg (dbg_o[g])
    );
  end

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int                dut;
    int                due;
    bit                rd;
    bit                err;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t             exp_q [$];
  logic [DATA_W-1:0] mem_m [NDUT][DEPTH];
  int                busy_until [NDUT];
  logic [DATA_W-1:0] rdata_m [NDUT];
  int                cyc;
  int                n_checks;
  int                n_fail;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Applies the request rules to the inputs present at the edge just taken.
  task automatic model_edge();
    int a;
    bit oor;
    bit rdy;
    a   = int'(addr);
    oor = (a >= DEPTH);
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      rdy = (cyc - 1 > busy_until[d]);
      if (rst) begin
        busy_until[d] = -1;
        rdata_m[d]    = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].dut == d) exp_q.delete(i);
      end else if (req && rdy) begin
        if (we) begin
          if (!oor)
            for (int l = 0; l < BE_W; l++)
              if (be[l]) mem_m[d][a][8*l +: 8] = wdata[8*l +: 8];
          exp_q.push_back('{dut: d, due: cyc, rd: 1'b0, err: oor, data: '0});
        end else begin
          exp_q.push_back('{dut: d, due: cyc + ws_of(d), rd: 1'b1, err: oor,
                            data: oor ? '0 : mem_m[d][a]});
          busy_until[d] = cyc + ws_of(d);
        end
      end
    end
  endtask

  task automatic check_outputs();
    int idx;
    bit e_rv, e_wa, e_er, e_rdy;
    for (int d = 0; d < NDUT; d++) begin
      idx = -1;
      e_rv = 1'b0; e_wa = 1'b0; e_er = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].dut == d && exp_q[i].due == cyc) idx = i;
      if (idx >= 0) begin
        e_rv = exp_q[idx].rd;
        e_wa = !exp_q[idx].rd;
        e_er = exp_q[idx].err;
        if (exp_q[idx].rd) rdata_m[d] = exp_q[idx].data;
        exp_q.delete(idx);
      end
      e_rdy = !rst && (cyc > busy_until[d]);
      check($sformatf("d%0d_rvalid", d), 32'(rvalid_o[d]), 32'(e_rv));
      check($sformatf("d%0d_wack", d),   32'(wack_o[d]),   32'(e_wa));
      check($sformatf("d%0d_err", d),    32'(err_o[d]),    32'(e_er));
      check($sformatf("d%0d_ready", d),  32'(ready_o[d]),  32'(e_rdy));
      check($sformatf("d%0d_rdata", d),  32'(rdata_o[d]),  32'(rdata_m[d]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit w, input int a, input logic [DATA_W-1:0] wd,
                       input logic [BE_W-1:0] b);
    req = 1'b1; we = w; addr = ADDR_W'(a); wdata = wd; be = b;
    tick();
    req = 1'b0;
  endtask

  // Idle until both instances are ready again (bounded).
  task automatic settle();
    int guard;
    guard = 0;
    req = 1'b0;
    while ((busy_until[0] >= cyc || busy_until[1] >= cyc) && guard < 50) begin
      tick();
      guard++;
    end
    check("settle_timeout", 32'(guard < 50), 32'd1);
  endtask

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 65)      return int'($urandom_range(0, 31));
    else if (r < 75) return 2046 + int'($urandom_range(0, 1));
    else if (r < 80) return 'h100;
    else             return int'($urandom_range(2048, 4095));
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_W-1:0] pre100;
    n_checks = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < NDUT; d++) begin
      busy_until[d] = -1;
      rdata_m[d]    = '0;
    end
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;

    // Reset then idle.
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_state_idle", d), 32'(dbg_o[d]), 32'(IDLE));
      check($sformatf("d%0d_rdata_reset", d), 32'(rdata_o[d]), 32'h0);
    end

    // Known contents for every in-range address the random phase touches.
    for (int a = 0; a < 32; a++) drive(1'b1, a, DATA_W'($urandom), 2'b11);
    drive(1'b1, 'h100, DATA_W'($urandom), 2'b11);
    drive(1'b1, 'h7FE, DATA_W'($urandom), 2'b11);
    drive(1'b1, 'h7FF, DATA_W'($urandom), 2'b11);
    tick();

    // Full write then read.
    drive(1'b1, 'h010, 16'hBEEF, 2'b11);
    drive(1'b0, 'h010, '0, '0);
    settle();
    check("d0_beef", 32'(rdata_o[0]), 32'hBEEF);
    check("d1_beef", 32'(rdata_o[1]), 32'hBEEF);

    // Byte lanes.
    drive(1'b1, 'h020, 16'h1234, 2'b11);
    drive(1'b1, 'h020, 16'hABCD, 2'b01);
    drive(1'b1, 'h020, 16'hFFFF, 2'b00);
    drive(1'b0, 'h020, '0, '0);
    settle();
    check("d0_lanes", 32'(rdata_o[0]), 32'h12CD);
    check("d1_lanes", 32'(rdata_o[1]), 32'h12CD);

    // Out of range: write must not alias onto 0x100.
    pre100 = mem_m[0]['h100];
    drive(1'b1, 'h900, 16'h5555, 2'b11);
    drive(1'b0, 'h100, '0, '0);
    settle();
    check("d1_no_alias", 32'(rdata_o[1]), 32'(pre100));
    drive(1'b0, 'h900, '0, '0);
    settle();
    check("d1_oor_rdata", 32'(rdata_o[1]), 32'h0);

    // Ignored request while busy, then reset mid-read.
    drive(1'b0, 'h010, '0, '0);
    drive(1'b1, 'h010, 16'h0BAD, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, 'h010, '0, '0);
    settle();
    check("d1_after_reset", 32'(rdata_o[1]), 32'hBEEF);

    // Back-to-back writes and readback.
    for (int a = 0; a < 4; a++) drive(1'b1, a, DATA_W'(16'hC0DE + a), 2'b11);
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, a, '0, '0);
      settle();
      check($sformatf("d1_b2b_%0d", a), 32'(rdata_o[1]), 32'(16'hC0DE + a));
    end

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      req   = ($urandom_range(0, 99) < 70);
      we    = 1'($urandom_range(0, 1));
      addr  = ADDR_W'(pick_addr());
      wdata = DATA_W'($urandom);
      be    = BE_W'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pending_responses", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
